// File: rtl/spike_isi_monitor.sv
// rtl/spike_isi_monitor.sv - spike edge ISI measurement with FWFT buffering and windowed rate count
module spike_isi_monitor #(
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 4,
    parameter int WINDOW = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     spike_in,
    input  logic                     clear,
    output logic [CNT_W-1:0]         isi_data,
    output logic                     isi_valid,
    input  logic                     isi_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               dropped,
    output logic [CNT_W-1:0]         rate_count,
    output logic                     rate_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             spike_q, spike_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rate_count_q, rate_count_d;
    logic             rate_valid_q, rate_valid_d;
    logic [7:0]       dropped_q, dropped_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] mem_q [DEPTH];

    logic             rise;
    logic             fifo_full;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             drop;
    logic             win_end;
    logic [CNT_W-1:0] acc_inc;

    always_comb begin
        rise      = spike_in & ~spike_q;
        fifo_full = (level_q == LW'(DEPTH));
        pop       = (level_q != '0) & isi_ready & ~clear;
        push_req  = rise & armed_q & ~clear;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push      = push_req & (~fifo_full | pop);
        drop      = push_req & fifo_full & ~pop;
        win_end   = (win_cnt_q == WW'(WINDOW - 1));
        acc_inc   = (acc_q == CNT_MAX) ? acc_q : acc_q + CNT_W'(rise);

        spike_d      = spike_in;
        armed_d      = armed_q;
        isi_cnt_d    = isi_cnt_q;
        win_cnt_d    = win_cnt_q;
        acc_d        = acc_q;
        rate_count_d = rate_count_q;
        rate_valid_d = 1'b0;
        dropped_d    = dropped_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;

        if (clear) begin
            armed_d   = 1'b0;
            isi_cnt_d = '0;
            win_cnt_d = '0;
            acc_d     = '0;
            dropped_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end else begin
            if (rise) begin
                armed_d   = 1'b1;
                isi_cnt_d = CNT_W'(1);
            end else if (isi_cnt_q != CNT_MAX) begin
                isi_cnt_d = isi_cnt_q + CNT_W'(1);
            end

            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            level_d  = level_q + LW'(push) - LW'(pop);

            if (drop && dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end

            if (win_end) begin
                win_cnt_d    = '0;
                rate_count_d = acc_inc;
                acc_d        = '0;
                rate_valid_d = 1'b1;
            end else begin
                win_cnt_d = win_cnt_q + WW'(1);
                acc_d     = acc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_q      <= 1'b0;
            armed_q      <= 1'b0;
            isi_cnt_q    <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            rate_count_q <= '0;
            rate_valid_q <= 1'b0;
            dropped_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            spike_q      <= spike_d;
            armed_q      <= armed_d;
            isi_cnt_q    <= isi_cnt_d;
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            rate_count_q <= rate_count_d;
            rate_valid_q <= rate_valid_d;
            dropped_q    <= dropped_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            if (push) begin
                mem_q[wr_ptr_q] <= isi_cnt_q;
            end
        end
    end

    assign isi_data   = mem_q[rd_ptr_q];
    assign isi_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign dropped    = dropped_q;
    assign rate_count = rate_count_q;
    assign rate_valid = rate_valid_q;

endmodule

// File: doc/spike_isi_monitor.md
Name: spike_isi_monitor

Overview:
- Downstream consumer of the neuron core's 1-bit spike output.
- Detects spike rising edges and measures the inter-spike interval (ISI) in clock cycles.
- Buffers ISIs in a small first-word-fall-through (FWFT) FIFO drained through a valid/ready handshake.
- Also reports a spike count per fixed window of cycles, for readout on the bidirectional IO pins or for later on-chip learning logic.

Parameters:
- CNT_W, 16: width of ISI values and of the rate count.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- WINDOW, 1000: rate window length in cycles; must be at least 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- spike_in  input  1  spike level from neuron core, synchronous to clk
- clear  input  1  synchronous flush, active high
- isi_data  output  CNT_W  ISI at FIFO head
- isi_valid  output  1  FIFO non-empty
- isi_ready  input  1  consumer accepts head
- fifo_level  output  clog2(DEPTH)+1  current occupancy
- dropped  output  8  count of ISIs lost to a full FIFO, saturating
- rate_count  output  CNT_W  spike edges in the last completed window
- rate_valid  output  1  one-cycle pulse when rate_count updates

Behaviour:
- Reset is asynchronous and active-low on reset_n. All state clears while reset_n=0:
  - isi_data=0, isi_valid=0, fifo_level=0, dropped=0, rate_count=0, rate_valid=0.
  - Disarmed, window counter=0, ISI counter=0, spike_q=0.
  - Reset asserted mid-operation discards FIFO contents and any partial interval.
- Edge detect: spike_q is spike_in registered. edge = spike_in & ~spike_q. A held-high spike counts once.
- ISI counter and arming:
  - Edge in cycle t while disarmed: set armed and load the counter with 1. Nothing is pushed.
  - Edge while armed: push the current counter value, then reload the counter with 1. The pushed ISI equals t1 - t0, where t0 and t1 are the two edge cycles.
  - When no edge occurs, the counter increments each cycle and saturates at 2^CNT_W-1. A saturated value is pushed as-is.
- FIFO (FWFT):
  - isi_valid = (level != 0); isi_data = head entry.
  - Pop when isi_valid & isi_ready.
  - A push lands at the tail and is visible one cycle later. There is no same-cycle bypass: a push into an empty FIFO raises isi_valid on the next cycle.
  - Push and pop in the same cycle: both occur and level is unchanged, including when the FIFO is full.
  - Push while full with no pop: the value is dropped, dropped increments (saturates at 255) and FIFO contents are unchanged.
  - Pointers wrap modulo DEPTH.
  - isi_data is held stable while isi_valid=1 and isi_ready=0.
- Rate window:
  - The window counter counts 0..WINDOW-1, then wraps to 0.
  - Edges increment an accumulator, which saturates at 2^CNT_W-1.
  - On the cycle the window counter equals WINDOW-1:
    - rate_count <= accumulator plus that cycle's edge.
    - The accumulator is set to 0.
    - rate_valid=1 on the following cycle for exactly one cycle.
  - The first window starts at the first cycle after reset release.
- clear (synchronous, high):
  - Empties the FIFO, disarms, zeros the ISI counter, window counter, accumulator and dropped.
  - rate_count keeps its last value; rate_valid is forced to 0.
  - Any edge in the same cycle is ignored; spike_q still updates.
  - clear has priority over push and pop.
- Latency:
  - Edge to isi_valid on an empty FIFO: 1 cycle.
  - Window end to rate_valid: 1 cycle.

Test Plan:
- Reset then spike pulses at cycles 10, 25 and 60 (each 1 cycle wide), isi_ready=1 -> isi_valid pulses twice, carrying isi_data 15 then 35. No entry for the first spike.
- Spike held high for 20 cycles from cycle 10, then a pulse at cycle 50 -> exactly one ISI of value 40. A held level never re-triggers.
- isi_ready=0 with 6 spikes, interval 5 each (DEPTH=4) -> fifo_level reaches 4 and dropped=1. Raising isi_ready then drains four entries of 5 in order, and isi_data stays stable while stalled.
- WINDOW=1000 with a spike every 100 cycles from cycle 1 -> rate_valid pulses every 1000 cycles with rate_count=10. A spike on the window's last cycle is counted in that window.
- No spikes for 70000 cycles after an arming spike (CNT_W=16), then a spike -> pushed ISI = 65535 (saturated).
- Mid-run, assert clear with the FIFO holding 3 entries and the module armed -> level 0 and isi_valid 0 next cycle, dropped=0. The next spike only re-arms and pushes nothing. Repeat with reset_n pulsed low asynchronously between clock edges -> all outputs 0 immediately.
